regfile_dump_reader: RTL and testbench

Sequential read-out engine on the read side of the 32x32 register file. On a start pulse it walks a configurable range of architectural registers through one asynchronous read port. It streams each `{index, value}` pair over a valid/ready interface to the testbench/print logic and keeps a running 32-bit checksum. It replaces whole-array exposure of the register file for end-of-program dumps.

---
 rtl/regfile_dump_reader_if.sv | 24 ++
 rtl/regfile_dump_reader.sv | 99 +++++++++
 tb/tb_regfile_dump_reader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Bundle between the dump reader, the register-file read port and the beat consumer.
// The master side is the dump engine; the slave side is the surrounding logic/testbench.
interface regfile_dump_reader_if;
  logic        start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  modport master (
    input  start, rd_data, out_ready,
    output rd_addr, out_valid, out_index, out_data, busy, done, checksum
  );

  modport slave (
    output start, rd_data, out_ready,
    input  rd_addr, out_valid, out_index, out_data, busy, done, checksum
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG through an async read port and streams
// {index, value} beats over valid/ready while accumulating a wrapping 32-bit checksum.
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_dump_reader_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  logic [1:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_index_q, out_index_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] checksum_q, checksum_d;
  logic        accept;

  assign accept = (state_q == S_SEND) && out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_READ;
          idx_d      = FIRST_IDX;
          checksum_d = 32'd0;
        end
      end
      S_READ: begin
        // The register value is captured here, so later writes to the file are not seen.
        out_data_d  = bus.rd_data;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          checksum_d  = checksum_q + out_data_q;
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= FIRST_IDX;
      out_valid_q <= 1'b0;
      out_index_q <= 5'd0;
      out_data_q  <= 32'd0;
      checksum_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
    end
  end

  assign bus.rd_addr   = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data  = out_data_q;
  assign bus.checksum  = checksum_q;
  assign bus.busy      = (state_q == S_READ) || (state_q == S_SEND);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: the stimulus side queues the beats and checksum a dump must produce
// from a register-file array; an independent monitor pops and compares each accepted beat.
`timescale 1ns/1ps
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_dump_reader_if bus0();
  regfile_dump_reader_if bus1();

  logic [31:0] regs [32];
  assign bus0.rd_data = regs[bus0.rd_addr];
  assign bus1.rd_data = regs[bus1.rd_addr];

  regfile_dump_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  regfile_dump_reader #(.FIRST_REG(10), .LAST_REG(10)) dutNarrow (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t       expQ[$];
  logic [31:0] csumQ[$];
  int checks = 0;
  int errors = 0;
  int beatCount = 0;
  int doneCount = 0;
  int readyMode = 0;
  bit held5 = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Consumer ready: 0 = always high, 1 = random, 2 = hold low 7 cycles on the index-5 beat
  initial begin
    bus0.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 1) begin
        bus0.out_ready = 1'($urandom_range(0, 1));
      end else if (readyMode == 2 && bus0.out_valid && bus0.out_index == 5'd5 && !held5) begin
        held5 = 1'b1;
        bus0.out_ready = 1'b0;
        repeat (7) begin
          @(negedge clk);
          checkOutput("bp_valid_held", 32'(bus0.out_valid), 32'd1);
          checkOutput("bp_index_stable", 32'(bus0.out_index), 32'd5);
          checkOutput("bp_data_stable", bus0.out_data, 32'hdeadbeef);
          @(posedge clk);
          #1;
        end
        bus0.out_ready = 1'b1;
      end else begin
        bus0.out_ready = 1'b1;
        if (readyMode != 2) held5 = 1'b0;
      end
    end
  end

  // Monitor: every accepted beat must be the next expected one; done must carry the expected sum
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        expQ.delete();
        csumQ.delete();
      end else begin
        if (bus0.out_valid && bus0.out_ready) begin
          beatCount++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got index %0d data 0x%08h, required no beat",
                     bus0.out_index, bus0.out_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("beat_index", 32'(bus0.out_index), 32'(e.idx));
            checkOutput("beat_data", bus0.out_data, e.data);
          end
        end
        if (bus0.done) begin
          doneCount++;
          if (csumQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1, required done=0");
          end else begin
            checkOutput("done_checksum", bus0.checksum, csumQ.pop_front());
          end
          checkOutput("busy_in_done", 32'(bus0.busy), 32'd0);
        end
      end
    end
  end

  task automatic queueExpected();
    logic [31:0] sum;
    beat_t b;
    sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = regs[i];
      expQ.push_back(b);
      sum = sum + regs[i];
    end
    csumQ.push_back(sum);
  endtask

  task automatic randomRegs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  task automatic clearRegs();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
  endtask

  // One full dump on the default-range instance, optionally poking start while busy
  task automatic applyStimulus(input bit busyStarts, input bit checkLatency);
    int cyc;
    int beatsBefore;
    int donesBefore;
    queueExpected();
    beatsBefore = beatCount;
    donesBefore = doneCount;
    @(posedge clk);
    #1 bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus0.start = busyStarts && (cyc % 7 == 3) && (cyc < 40);
      if (bus0.done) break;
    end
    if (!bus0.done) begin
      checks++;
      errors++;
      $display("[TB] FAIL dump_timeout: got no done after %0d cycles, required done", cyc);
      $fatal(1, "[TB] dump did not complete");
    end
    if (checkLatency) checkOutput("done_latency", 32'(cyc), 32'd65);
    checkOutput("beats_per_dump", 32'(beatCount - beatsBefore), 32'd32);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(bus0.done), 32'd0);
    checkOutput("busy_after_done", 32'(bus0.busy), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("dones_per_dump", 32'(doneCount - donesBefore), 32'd1);
    checkOutput("no_restart", 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] keptSum;
    reset = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus1.out_ready = 1'b1;
    clearRegs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus0.busy), 32'd0);
    checkOutput("rst_done", 32'(bus0.done), 32'd0);
    checkOutput("rst_checksum", bus0.checksum, 32'd0);
    checkOutput("rst_rd_addr", 32'(bus0.rd_addr), 32'd0);
    checkOutput("rst_out_index", 32'(bus0.out_index), 32'd0);
    checkOutput("rst_out_data", bus0.out_data, 32'd0);
    checkOutput("rst_rd_addr_narrow", 32'(bus1.rd_addr), 32'd10);

    $display("[TB] full dump of reset-state register file");
    clearRegs();
    regs[2] = 32'h00002ffc;
    readyMode = 0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("full_checksum", bus0.checksum, 32'h00002ffc);

    $display("[TB] backpressure on index 5");
    randomRegs();
    regs[5] = 32'hdeadbeef;
    readyMode = 2;
    applyStimulus(1'b0, 1'b0);
    readyMode = 0;

    $display("[TB] checksum wrap");
    clearRegs();
    regs[1] = 32'hffffffff;
    regs[3] = 32'h00000002;
    readyMode = 1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("wrap_checksum", bus0.checksum, 32'h00000001);
    readyMode = 0;

    $display("[TB] start pulses while busy");
    randomRegs();
    applyStimulus(1'b1, 1'b1);

    $display("[TB] reset while index 12 pending");
    randomRegs();
    queueExpected();
    @(posedge clk);
    #1 bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    cyc = 0;
    while (!(bus0.out_valid && bus0.out_index == 5'd12) && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("reach_index12", 32'(bus0.out_valid && bus0.out_index == 5'd12), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(bus0.busy), 32'd0);
    checkOutput("midrst_checksum", bus0.checksum, 32'd0);
    checkOutput("midrst_rd_addr", 32'(bus0.rd_addr), 32'd0);
    randomRegs();
    applyStimulus(1'b0, 1'b1);

    $display("[TB] random dumps with random backpressure");
    readyMode = 1;
    for (int n = 0; n < 3; n++) begin
      randomRegs();
      applyStimulus(1'b0, 1'b0);
      keptSum = 32'd0;
      for (int i = 0; i < 32; i++) keptSum = keptSum + regs[i];
      checkOutput("checksum_retained", bus0.checksum, keptSum);
    end
    readyMode = 0;

    $display("[TB] single-register range");
    randomRegs();
    regs[10] = 32'h12345678;
    @(posedge clk);
    #1 bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus1.out_valid && cyc < 50);
    checkOutput("narrow_valid", 32'(bus1.out_valid), 32'd1);
    checkOutput("narrow_index", 32'(bus1.out_index), 32'd10);
    checkOutput("narrow_data", bus1.out_data, 32'h12345678);
    @(negedge clk);
    checkOutput("narrow_done", 32'(bus1.done), 32'd1);
    checkOutput("narrow_checksum", bus1.checksum, 32'h12345678);
    checkOutput("narrow_valid_cleared", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("narrow_done_cleared", 32'(bus1.done), 32'd0);
    checkOutput("narrow_busy_cleared", 32'(bus1.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
